// File: rtl/meter_pkg.sv
// ============================================================================
// Module   : meter_pkg
// Purpose  : Shared channel indices, debounce state encoding and arbiter helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package meter_pkg;

   localparam int CH_RST1 = 0;
   localparam int CH_RST2 = 1;
   localparam int CH_ADD1 = 2;
   localparam int CH_ADD2 = 3;
   localparam int CH_ADD3 = 4;
   localparam int CH_ADD4 = 5;
   localparam int NUM_CH  = 6;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CNT = 2'd1,
      HELD      = 2'd2,
      REL_CNT   = 2'd3
   } db_state_e;

   // One-hot of the lowest set bit; bit 0 has the highest priority.
   function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] req);
      logic [NUM_CH-1:0] g;
      g = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            g    = '0;
            g[i] = 1'b1;
         end
      end
      return g;
   endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_if.sv
// ============================================================================
// Module   : button_conditioner_if
// Purpose  : Raw button levels in, single-cycle meter command pulses out
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_conditioner_if;

   logic btn_add1;
   logic btn_add2;
   logic btn_add3;
   logic btn_add4;
   logic btn_rst1;
   logic btn_rst2;

   logic add1;
   logic add2;
   logic add3;
   logic add4;
   logic rst1;
   logic rst2;

   modport master (
      output btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
      input  add1, add2, add3, add4, rst1, rst2
   );

   modport slave (
      input  btn_add1, btn_add2, btn_add3, btn_add4, btn_rst1, btn_rst2,
      output add1, add2, add3, add4, rst1, rst2
   );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchroniser plus press/release debounce FSM for one button
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
   import meter_pkg::*;
#(
   parameter int DB_CYCLES = 3,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic press_o
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES);

   logic            sync1_q;
   logic            sync2_q;
   db_state_e       state_q;
   db_state_e       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_inc = cnt_q + CNT_W'(1);

   // press_o is a combinational strobe so the pending bit lands on the accepting edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               if (DB_CYCLES == 1) begin
                  state_d = HELD;
                  cnt_d   = '0;
                  press_o = 1'b1;
               end else begin
                  state_d = PRESS_CNT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         PRESS_CNT: begin
            if (!sync2_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_inc == DB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               press_o = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HELD: begin
            if (!sync2_q) begin
               if (DB_CYCLES == 1) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  state_d = REL_CNT;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         REL_CNT: begin
            if (sync2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_inc == DB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Six debounced buttons, one-deep press queue, priority-serialised pulses
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner
   import meter_pkg::*;
#(
   parameter int DB_CYCLES = 3,
   parameter int CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);

   logic [NUM_CH-1:0] raw;
   logic [NUM_CH-1:0] press;
   logic [NUM_CH-1:0] grant;
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] pend_d;
   logic [NUM_CH-1:0] out_q;

   assign raw[CH_RST1] = bus.btn_rst1;
   assign raw[CH_RST2] = bus.btn_rst2;
   assign raw[CH_ADD1] = bus.btn_add1;
   assign raw[CH_ADD2] = bus.btn_add2;
   assign raw[CH_ADD3] = bus.btn_add3;
   assign raw[CH_ADD4] = bus.btn_add4;

   generate
      for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
         btn_debounce #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (raw[ch]),
            .press_o (press[ch])
         );
      end
   endgenerate

   // A new press on the channel being granted this cycle stays queued.
   assign grant  = lowest_set(pend_q);
   assign pend_d = (pend_q & ~grant) | press;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         out_q  <= '0;
      end else begin
         pend_q <= pend_d;
         out_q  <= grant;
      end
   end

   assign bus.rst1 = out_q[CH_RST1];
   assign bus.rst2 = out_q[CH_RST2];
   assign bus.add1 = out_q[CH_ADD1];
   assign bus.add2 = out_q[CH_ADD2];
   assign bus.add3 = out_q[CH_ADD3];
   assign bus.add4 = out_q[CH_ADD4];

endmodule

`default_nettype wire
